// File: rtl/fp16_addsub_arbiter_if.sv
// rtl/fp16_addsub_arbiter_if.sv - requester, adder and response signals of the shared FP16 add/sub arbiter
interface fp16_addsub_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_op;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic                  add_i_valid;
  logic [15:0]           add_i_a;
  logic [15:0]           add_i_b;
  logic [15:0]           add_o_res;
  logic                  add_o_ovf;
  logic                  add_o_vld;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_res;
  logic                  rsp_ovf;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;
  logic                  stray_vld;

  modport master (
    input  req_valid, req_op, req_a, req_b, add_o_res, add_o_ovf, add_o_vld, rsp_ready,
    output req_ready, add_i_valid, add_i_a, add_i_b, rsp_valid, rsp_res, rsp_ovf, rsp_id,
           busy, stray_vld
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, add_o_res, add_o_ovf, add_o_vld, rsp_ready,
    input  req_ready, add_i_valid, add_i_a, add_i_b, rsp_valid, rsp_res, rsp_ovf, rsp_id,
           busy, stray_vld
  );
endinterface

// File: rtl/fp16_addsub_arbiter.sv
// rtl/fp16_addsub_arbiter.sv - round-robin sharing of one registered FP16 adder among NUM_REQ requesters
module fp16_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fp16_addsub_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            grant_found;
  logic [ID_W:0]   cand;
  logic [15:0]     sel_a;
  logic [15:0]     sel_b;
  logic            sel_op;
  logic            add_i_valid_r;
  logic [15:0]     op_a;
  logic [15:0]     op_b;
  logic            rsp_valid_r;
  logic [15:0]     rsp_res_r;
  logic            rsp_ovf_r;
  logic [ID_W-1:0] rsp_id_r;
  logic            stray_r;

  // Walk from the farthest offset back to rr_ptr so the nearest pending requester wins.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (bus.req_valid[cand[ID_W-1:0]]) begin
        grant       = cand[ID_W-1:0];
        grant_found = 1'b1;
      end
    end
  end

  assign sel_a  = bus.req_a[{grant, 4'b0000} +: 16];
  assign sel_b  = bus.req_b[{grant, 4'b0000} +: 16];
  assign sel_op = bus.req_op[grant];

  // Gated by rst so every output reads 0 while reset is asserted.
  assign bus.req_ready = (state == IDLE && grant_found && !rst) ? (NUM_REQ'(1) << grant) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      add_i_valid_r <= 1'b0;
      op_a          <= '0;
      op_b          <= '0;
      rsp_valid_r   <= 1'b0;
      rsp_res_r     <= '0;
      rsp_ovf_r     <= 1'b0;
      rsp_id_r      <= '0;
      stray_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a          <= sel_a;
            op_b          <= {sel_b[15] ^ sel_op, sel_b[14:0]};
            rsp_id_r      <= grant;
            rr_ptr        <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            add_i_valid_r <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          add_i_valid_r <= 1'b0;
          state         <= WAIT;
        end
        WAIT: begin
          if (bus.add_o_vld) begin
            rsp_res_r   <= bus.add_o_res;
            rsp_ovf_r   <= bus.add_o_ovf;
            rsp_valid_r <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (bus.add_o_vld && state != WAIT) begin
        stray_r <= 1'b1;
      end
    end
  end

  assign bus.add_i_valid = add_i_valid_r;
  assign bus.add_i_a     = op_a;
  assign bus.add_i_b     = op_b;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_res     = rsp_res_r;
  assign bus.rsp_ovf     = rsp_ovf_r;
  assign bus.rsp_id      = rsp_id_r;
  assign bus.busy        = (state != IDLE);
  assign bus.stray_vld   = stray_r;
endmodule

// File: tb/tb_fp16_addsub_arbiter.sv
// tb/tb_fp16_addsub_arbiter.sv - scoreboard bench with a real-arithmetic FP16 adder model
module tb_fp16_addsub_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp16_addsub_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();
  fp16_addsub_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b_eff;
    logic [15:0] res;
    logic        ovf;
    int          t;
  } exp_t;

  exp_t iss_q[$];
  exp_t rsp_q[$];
  int   obs_order[$];

  bit          pend[N];
  logic [15:0] pa[N];
  logic [15:0] pb[N];
  logic        pop[N];
  int          last_g      = -1;
  bit          outstanding = 1'b0;
  bit          seen        = 1'b0;
  int          rdy_mode    = 0;
  bit          hold_adder  = 1'b0;
  bit          stray_req   = 1'b0;
  logic [15:0] last_res;
  logic        last_ovf;
  int          last_id;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic real h2r(logic [15:0] h);
    real r;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) r = real'(int'(h[9:0])) * 2.0 ** (-24);
    else        r = real'(1024 + int'(h[9:0])) * 2.0 ** (e - 25);
    return h[15] ? -r : r;
  endfunction

  // Returns {overflow, fp16}; round to nearest, overflow saturates to infinity.
  function automatic logic [16:0] r2h(real r);
    logic s;
    real  a;
    int   e;
    int   v;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a == 0.0) return 17'h0;
    if (a >= 65520.0) return {1'b1, s, 15'h7c00};
    if (a < 2.0 ** (-14)) begin
      v = int'(a / 2.0 ** (-24));
      return {1'b0, s, 15'(v)};
    end
    e = -14;
    while (a >= 2.0 ** (e + 1)) e++;
    v = (e + 15) * 1024 + int'((a / 2.0 ** e - 1.0) * 1024.0);
    if (v >= 31 * 1024) return {1'b1, s, 15'h7c00};
    return {1'b0, s, 15'(v)};
  endfunction

  function automatic logic [15:0] rand_h();
    return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
  endfunction

  // Adder stand-in: one-cycle registered sum of the operands it is handed.
  always @(posedge clk) begin : adder_model
    logic [16:0] s;
    s = r2h(h2r(bus.add_i_a) + h2r(bus.add_i_b));
    bus.add_o_vld <= (bus.add_i_valid & ~hold_adder) | stray_req;
    bus.add_o_res <= s[15:0];
    bus.add_o_ovf <= s[16];
  end

  always @(posedge clk) cyc++;

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]         = pend[i];
      bus.req_op[i]            = pop[i];
      bus.req_a[16*i +: 16]    = pa[i];
      bus.req_b[16*i +: 16]    = pb[i];
    end
    bus.rsp_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (rdy_mode == 0);
  endtask

  task automatic new_req(int i, logic [15:0] a, logic [15:0] b, logic op);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
    pop[i]  = op;
  endtask

  // One cycle: drive at the falling edge, then judge the grant that the next rising edge commits.
  task automatic step();
    int   exp_g;
    int   j;
    exp_t e;
    real  bv;
    logic [16:0] s;
    @(negedge clk);
    apply_inputs();
    #1;
    if (!rst) begin
      exp_g = -1;
      if (!outstanding) begin
        for (int k = 1; k <= N; k++) begin
          j = (last_g + k) % N;
          if (pend[j] && exp_g < 0) exp_g = j;
        end
      end
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) obs_order.push_back(i);
      check("req_ready", 32'(bus.req_ready), (exp_g >= 0) ? (32'd1 << exp_g) : 32'd0);
      if (exp_g >= 0) begin
        bv      = pop[exp_g] ? -h2r(pb[exp_g]) : h2r(pb[exp_g]);
        s       = r2h(h2r(pa[exp_g]) + bv);
        e.id    = exp_g;
        e.a     = pa[exp_g];
        e.b_eff = {pb[exp_g][15] ^ pop[exp_g], pb[exp_g][14:0]};
        e.res   = s[15:0];
        e.ovf   = s[16];
        e.t     = cyc;
        iss_q.push_back(e);
        rsp_q.push_back(e);
        last_g       = exp_g;
        outstanding  = 1'b1;
        pend[exp_g]  = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (!rst) begin
      if (bus.add_i_valid) begin
        if (iss_q.size() == 0) check("add_i_valid_unexpected", bus.add_i_valid, 0);
        else begin
          e = iss_q.pop_front();
          check("add_i_a", bus.add_i_a, e.a);
          check("add_i_b", bus.add_i_b, e.b_eff);
          check("add_i_latency", cyc, e.t + 1);
        end
      end
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_valid_unexpected", bus.rsp_valid, 0);
        else begin
          e = rsp_q[0];
          if (!seen) begin
            check("rsp_latency", cyc, e.t + 3);
            seen = 1'b1;
          end
          check("rsp_res", bus.rsp_res, e.res);
          check("rsp_ovf", bus.rsp_ovf, e.ovf);
          check("rsp_id", 32'(bus.rsp_id), e.id);
          if (bus.rsp_ready) begin
            void'(rsp_q.pop_front());
            last_res    = bus.rsp_res;
            last_ovf    = bus.rsp_ovf;
            last_id     = int'(bus.rsp_id);
            seen        = 1'b0;
            outstanding = 1'b0;
          end
        end
      end
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_add_i_valid"}, bus.add_i_valid, 0);
    check({tag, "_add_i_a"}, bus.add_i_a, 0);
    check({tag, "_add_i_b"}, bus.add_i_b, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_res"}, bus.rsp_res, 0);
    check({tag, "_rsp_ovf"}, bus.rsp_ovf, 0);
    check({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_stray_vld"}, bus.stray_vld, 0);
  endtask

  task automatic drain(string tag);
    int  n;
    bit  any;
    n   = 0;
    any = 1'b1;
    while (any && n < 200) begin
      any = outstanding;
      for (int i = 0; i < N; i++) any |= pend[i];
      if (any) step();
      n++;
    end
    check({tag, "_drain_timeout"}, any, 0);
  endtask

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    int exp_order[5];
    int n;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pop[i] = 1'b0;
    end
    rdy_mode = 2;
    apply_inputs();
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst      = 1'b0;
    rdy_mode = 0;

    // Round robin with every requester asserted continuously from rr_ptr=0.
    obs_order.delete();
    for (int i = 0; i < N; i++) new_req(i, rand_h(), rand_h(), 1'($urandom));
    n = 0;
    while (obs_order.size() < 5 && n < 60) begin
      step();
      for (int i = 0; i < N; i++) if (!pend[i] && obs_order.size() < 5) new_req(i, rand_h(), rand_h(), 1'($urandom));
      n++;
    end
    check("rr_grant_count", obs_order.size(), 5);
    for (int i = 0; i < 5 && i < obs_order.size(); i++) check($sformatf("rr_order_%0d", i), obs_order[i], exp_order[i]);
    drain("rr");

    new_req(0, 16'h3c00, 16'h4000, 1'b0);
    drain("add");
    check("add_res", last_res, 16'h4200);
    check("add_id", last_id, 0);

    new_req(2, 16'h4200, 16'h3c00, 1'b1);
    drain("sub");
    check("sub_res", last_res, 16'h4000);
    check("sub_ovf", last_ovf, 0);
    check("sub_id", last_id, 2);

    new_req(1, 16'h7bff, 16'h7bff, 1'b0);
    drain("ovf");
    check("ovf_res", last_res, 16'h7c00);
    check("ovf_ovf", last_ovf, 1);
    check("stray_clear", bus.stray_vld, 0);

    // Back-pressure, with a competing request and a stray adder pulse during RESP.
    rdy_mode = 2;
    new_req(3, 16'h4400, 16'h3800, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin step(); n++; end
    check("bp_rsp_seen", bus.rsp_valid, 1);
    new_req(0, 16'h3c00, 16'h3c00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      stray_req = (i == 4);
      step();
    end
    stray_req = 1'b0;
    check("bp_stray_vld", bus.stray_vld, 1);
    check("bp_busy", bus.busy, 1);
    rdy_mode = 0;
    step();
    step();
    check("bp_rsp_dropped", bus.rsp_valid, 0);
    drain("bp");

    // Randomized traffic with random back-pressure and dropped requests.
    rdy_mode = 1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) new_req(i, rand_h(), rand_h(), 1'($urandom));
        else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
      end
      step();
    end
    rdy_mode = 0;
    drain("rand");

    // Reset while waiting on the adder, then a stray adder pulse in IDLE.
    hold_adder = 1'b1;
    new_req(1, 16'h3c00, 16'h3c00, 1'b0);
    step();
    step();
    step();
    check("wait_busy", bus.busy, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    pend[2] = 1'b1;
    apply_inputs();
    #1;
    check_zero("rst_wait");
    iss_q.delete();
    rsp_q.delete();
    outstanding = 1'b0;
    seen        = 1'b0;
    last_g      = -1;
    hold_adder  = 1'b0;
    pend[2]     = 1'b0;
    @(negedge clk);
    apply_inputs();
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst       = 1'b0;
    stray_req = 1'b1;
    step();
    stray_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_rsp_valid", bus.rsp_valid, 0);
    end
    check("post_rst_stray_vld", bus.stray_vld, 1);
    check("post_rst_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
